fp_add_scheduler: RTL and testbench
===================================

// Module: fp_add_scheduler
// PURPOSE
//  Round-robin scheduler sharing one multi-cycle single-precision FP adder among NREQ requesters.
//  Accepts one operand pair at a time over a valid/ready handshake and drives the adder's start/operands.
//  Waits for the adder's done (with timeout) and returns sum or error to the granted requester only.
//  Sits between the requester clients and the single FP addition datapath instance.
// PARAMETERS
//  NREQ     4   number of requesters (2..8)
//  W        32  operand/result width (IEEE-754 single)
//  TIMEOUT  64  max cycles in WAIT before error response (>=2)
// PORTS
//  clk        in   1       system clock, rising edge
//  reset      in   1       asynchronous, active-low reset
//  req_valid  in   NREQ    per-requester operand pair valid
//  req_x      in   NREQ*W  operand x, requester i at [i*W +: W]
//  req_y      in   NREQ*W  operand y, same packing
//  req_ready  out  NREQ    one-hot, 1-cycle accept pulse
//  rsp_valid  out  NREQ    one-hot, 1-cycle result pulse to granted requester
//  rsp_sum    out  W       result, valid with rsp_valid
//  rsp_err    out  1       1 = adder timed out, rsp_sum forced 0
//  add_x      out  W       adder operand x, held from ISSUE through WAIT
//  add_y      out  W       adder operand y, held from ISSUE through WAIT
//  add_start  out  1       1-cycle adder start pulse
//  add_done   in   1       adder result valid (1-cycle pulse)
//  add_sum    in   W       adder result, sampled when add_done=1 in WAIT
//  busy       out  1       1 in every state except IDLE
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, all outputs 0, grant=0, timer=0, ptr=NREQ-1 (first priority to req 0).
//  Reset mid-operation aborts the in-flight op; no response issued; requester must re-request.
//  FSM states: IDLE, ISSUE, WAIT, RESP.
//  IDLE: if |req_valid, pick g = first set bit searching ptr+1, ptr+2, ... (mod NREQ).
//    Same cycle: req_ready[g]=1 (combinational from registered ptr/state).
//    Edge: latch req_x[g], req_y[g] into add_x/add_y; grant<=g; go ISSUE. Else stay.
//  ISSUE: add_start=1 for exactly this cycle; timer<=0; go WAIT. add_done here ignored.
//  WAIT: add_done=1 -> latch add_sum into rsp_sum, rsp_err<=0, go RESP.
//    Else timer++; timer==TIMEOUT-1 without done -> rsp_sum<=0, rsp_err<=1, go RESP.
//    done and timeout in same cycle: done wins.
//  RESP: rsp_valid[grant]=1 one cycle; ptr<=grant; go IDLE. rsp_sum/rsp_err hold until next RESP.
//  add_done outside WAIT ignored (late done after timeout is dropped).
//  Latency: accept cycle A, start A+1; adder latency L (done at A+1+L) -> rsp_valid at A+2+L.
//  Throughput: one op per L+3 cycles; adder never sees a second start before done/timeout.
//  Requester rules: hold req_valid and operands stable until req_ready; withdrawal before grant allowed.
//  Fairness: all requesting -> grants 0,1,..,NREQ-1,0,...; wait bound NREQ-1 ops.
//  No arithmetic on operands; scheduler is width-transparent. timer width = clog2(TIMEOUT).
// STRUCTURE
//  Package fp_add_pkg: state encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3), FP_W=32,
//    FP_ONE=32'h3F80_0000, FP_TWO=32'h4000_0000, FP_THREE=32'h4040_0000.
//  Sub-module rr_pick (combinational): in req[NREQ], ptr -> one-hot gnt, index g, any.
//  Top: FSM, operand/result registers, timeout counter, output decode.
// TESTING (adder model: fixed L=3 unless stated)
//  1 Reset mid-WAIT: req0 x=FP_ONE,y=FP_TWO, assert reset=0 during WAIT -> all outputs 0 immediately,
//    no rsp_valid, adder later done ignored; next request granted to req 0.
//  2 Single op: req1 x=FP_ONE, y=FP_TWO at cycle 0 -> req_ready=4'b0010 cycle 0, add_start cycle 1,
//    rsp_valid=4'b0010, rsp_sum=FP_THREE, rsp_err=0 at cycle 5.
//  3 Round robin: req_valid=4'b1111 held -> grant order 0,1,2,3,0; each rsp_valid one-hot matches grant.
//  4 Timeout: model never asserts done -> rsp_err=1, rsp_sum=0 exactly TIMEOUT+1 cycles after
//    add_start; done pulsed afterwards ignored.
//  5 Done/timeout collision: done on final WAIT cycle with add_sum=FP_TWO -> rsp_err=0, rsp_sum=FP_TWO.
//  6 Withdrawal/skip: req2 valid then dropped before grant while req0 busy -> req2 never granted,
//    next grant goes to req3 if valid; add_start never re-pulses while busy.

Source files
------------

// File: rtl/fp_add_pkg.sv
// Shared encodings and FP constants for the shared FP adder scheduler.
package fp_add_pkg;

    localparam int unsigned FP_W = 32;

    localparam logic [FP_W-1:0] FP_ONE   = 32'h3F80_0000;
    localparam logic [FP_W-1:0] FP_TWO   = 32'h4000_0000;
    localparam logic [FP_W-1:0] FP_THREE = 32'h4040_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/fp_add_scheduler_if.sv
// Requester and adder-side signal bundle for fp_add_scheduler.
interface fp_add_scheduler_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 32
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_x;
    logic [NREQ*W-1:0] req_y;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [W-1:0]      rsp_sum;
    logic              rsp_err;
    logic [W-1:0]      add_x;
    logic [W-1:0]      add_y;
    logic              add_start;
    logic              add_done;
    logic [W-1:0]      add_sum;

    // Scheduler side
    modport slave (
        input  req_valid, req_x, req_y, add_done, add_sum,
        output req_ready, rsp_valid, rsp_sum, rsp_err, add_x, add_y, add_start
    );

    // Requesters plus adder side
    modport master (
        output req_valid, req_x, req_y, add_done, add_sum,
        input  req_ready, rsp_valid, rsp_sum, rsp_err, add_x, add_y, add_start
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first request after ptr, wrapping mod NREQ.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    localparam int unsigned IW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   g,
    output logic            any
);

    logic [IW-1:0] idx;

    always_comb begin
        gnt = '0;
        g   = '0;
        any = 1'b0;
        idx = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx = IW'((32'(ptr) + i) % NREQ);
            if (!any && req[idx]) begin
                any      = 1'b1;
                g        = idx;
                gnt[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_add_scheduler.sv
// Round-robin scheduler sharing one multi-cycle FP adder among NREQ requesters.
module fp_add_scheduler
    import fp_add_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned W       = FP_W,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    fp_add_scheduler_if.slave bus,
    output logic             busy
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned TW = $clog2(TIMEOUT);

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   grant;
    logic [IW-1:0]   ptr;
    logic [TW-1:0]   timer;
    logic [W-1:0]    add_x_q;
    logic [W-1:0]    add_y_q;
    logic [W-1:0]    rsp_sum_q;
    logic            rsp_err_q;
    logic            timeout_hit;

    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_g;
    logic            pick_any;

    logic [NREQ-1:0] req_ready_c;
    logic [NREQ-1:0] rsp_valid_c;
    logic            add_start_c;
    logic            busy_c;

    logic [W-1:0]    op_x [NREQ];
    logic [W-1:0]    op_y [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_ops
        assign op_x[i] = bus.req_x[i*W +: W];
        assign op_y[i] = bus.req_y[i*W +: W];
    end

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req (bus.req_valid),
        .ptr (ptr),
        .gnt (pick_gnt),
        .g   (pick_g),
        .any (pick_any)
    );

    assign timeout_hit = (timer == TW'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; a done on the final WAIT cycle takes the same RESP path as a timeout
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (pick_any) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (bus.add_done || timeout_hit) state_nxt = ST_RESP;
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Output decode; ready is held low while reset is asserted
    always_comb begin
        req_ready_c = '0;
        rsp_valid_c = '0;
        add_start_c = 1'b0;
        busy_c      = 1'b0;
        case (state)
            ST_IDLE:  req_ready_c = reset ? pick_gnt : '0;
            ST_ISSUE: begin
                add_start_c = 1'b1;
                busy_c      = 1'b1;
            end
            ST_WAIT:  busy_c = 1'b1;
            ST_RESP:  begin
                rsp_valid_c = NREQ'(1) << grant;
                busy_c      = 1'b1;
            end
            default:  ;
        endcase
    end

    // Operand capture, timeout counter, result registers, priority pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            add_x_q   <= '0;
            add_y_q   <= '0;
            rsp_sum_q <= '0;
            rsp_err_q <= 1'b0;
            grant     <= '0;
            timer     <= '0;
            ptr       <= IW'(NREQ - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        add_x_q <= op_x[pick_g];
                        add_y_q <= op_y[pick_g];
                        grant   <= pick_g;
                    end
                end
                ST_ISSUE: timer <= '0;
                ST_WAIT: begin
                    if (bus.add_done) begin
                        rsp_sum_q <= bus.add_sum;
                        rsp_err_q <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_sum_q <= '0;
                        rsp_err_q <= 1'b1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                ST_RESP: ptr <= grant;
                default: ;
            endcase
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_c;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.add_x     = add_x_q;
    assign bus.add_y     = add_y_q;
    assign bus.add_start = add_start_c;
    assign busy          = busy_c;

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Directed bench for fp_add_scheduler with a fixed/variable-latency adder model.
module tb_fp_add_scheduler;
    import fp_add_pkg::*;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned W       = 32;
    localparam int unsigned TIMEOUT = 16;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  gnt;
        logic [31:0] sum;
        logic        err;
        int          lat;      // 0 = adder never answers
        logic        ovr;      // adder returns FP_TWO regardless of operands
        int          resp_at;  // cycles from accept to rsp_valid
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic busy;

    fp_add_scheduler_if #(.NREQ(NREQ), .W(W)) bus ();

    fp_add_scheduler #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    logic [31:0] op_x [4];
    logic [31:0] op_y [4];
    int   checks = 0;
    int   errors = 0;
    int   lat_cfg = 3;
    logic use_ovr = 1'b0;
    logic manual_done = 1'b0;
    logic model_done = 1'b0;
    int   remaining = 0;
    vec_t tbl [10];

    function automatic logic [31:0] model_sum(input logic [31:0] a, input logic [31:0] b);
        if ((a == FP_ONE && b == FP_TWO) || (a == FP_TWO && b == FP_ONE)) return FP_THREE;
        if (a == FP_ONE && b == FP_ONE) return FP_TWO;
        return a ^ b;
    endfunction

    function automatic int oh_idx(input logic [3:0] v);
        for (int k = 0; k < 4; k++) if (v[k]) return k;
        return 0;
    endfunction

    assign bus.req_x    = {op_x[3], op_x[2], op_x[1], op_x[0]};
    assign bus.req_y    = {op_y[3], op_y[2], op_y[1], op_y[0]};
    assign bus.add_done = model_done | manual_done;
    assign bus.add_sum  = use_ovr ? FP_TWO : model_sum(bus.add_x, bus.add_y);

    // Adder model: done pulses lat_cfg cycles after the start cycle
    always @(posedge clk) begin
        model_done <= 1'b0;
        if (bus.add_start && lat_cfg > 0) begin
            if (lat_cfg == 1) model_done <= 1'b1;
            else              remaining  <= lat_cfg - 1;
        end else if (remaining > 0) begin
            remaining <= remaining - 1;
            if (remaining == 1) model_done <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_op(input vec_t v);
        int n;
        int gi;
        gi      = oh_idx(v.gnt);
        lat_cfg = v.lat;
        use_ovr = v.ovr;
        bus.req_valid = v.valid;
        #1;
        chk("req_ready", 32'(bus.req_ready), 32'(v.gnt));
        @(negedge clk); #1;
        chk("add_start", 32'(bus.add_start), 32'd1);
        chk("add_x", bus.add_x, op_x[gi]);
        chk("add_y", bus.add_y, op_y[gi]);
        n = 1;
        while (bus.rsp_valid == '0 && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        chk("resp_cycle", 32'(n), 32'(v.resp_at));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(v.gnt));
        chk("rsp_sum", bus.rsp_sum, v.sum);
        chk("rsp_err", 32'(bus.rsp_err), 32'(v.err));
        chk("add_x_hold", bus.add_x, op_x[gi]);
        @(negedge clk); #1;
        chk("rsp_valid_idle", 32'(bus.rsp_valid), 32'd0);
        chk("rsp_sum_hold", bus.rsp_sum, v.sum);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    task automatic reset_mid_wait();
        logic seen;
        op_y[0] = FP_TWO;
        lat_cfg = 3;
        use_ovr = 1'b0;
        bus.req_valid = 4'b0001;
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'b0001);
        @(negedge clk); #1;
        bus.req_valid = 4'b0000;
        chk("rst_add_start", 32'(bus.add_start), 32'd1);
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("rst_busy_wait", 32'(busy), 32'd1);
        chk("rst_add_y_wait", bus.add_y, FP_TWO);
        #1 reset = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_add_x", bus.add_x, 32'd0);
        chk("rst_add_y", bus.add_y, 32'd0);
        chk("rst_rsp_sum", bus.rsp_sum, 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk); #1;
            if (bus.rsp_valid != '0) seen = 1'b1;
        end
        reset   = 1'b1;
        op_y[0] = FP_ONE;
        repeat (2) begin
            @(negedge clk); #1;
            if (bus.rsp_valid != '0 || busy) seen = 1'b1;
        end
        chk("rst_no_rsp", 32'(seen), 32'd0);
    endtask

    task automatic late_done_check();
        bus.req_valid = 4'b0000;
        manual_done   = 1'b1;
        @(negedge clk); #1;
        manual_done = 1'b0;
        chk("late_done_busy", 32'(busy), 32'd0);
        chk("late_done_rsp", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk); #1;
        chk("late_done_rsp2", 32'(bus.rsp_valid), 32'd0);
    endtask

    task automatic withdraw_seq();
        int   n;
        int   starts;
        logic bad_ready;
        lat_cfg = 3;
        use_ovr = 1'b0;
        bus.req_valid = 4'b0001;
        #1;
        chk("wd_req_ready", 32'(bus.req_ready), 32'b0001);
        n = 0;
        starts = 0;
        bad_ready = 1'b0;
        while (n < 40) begin
            @(negedge clk); #1;
            n++;
            starts += int'(bus.add_start);
            if (bus.req_ready != '0) bad_ready = 1'b1;
            if (n == 1) bus.req_valid = 4'b0100;
            if (n == 3) bus.req_valid = 4'b1000;
            if (bus.rsp_valid != '0) break;
        end
        chk("wd_resp_cycle", 32'(n), 32'd5);
        chk("wd_rsp_valid", 32'(bus.rsp_valid), 32'b0001);
        chk("wd_start_count", 32'(starts), 32'd1);
        chk("wd_ready_busy", 32'(bad_ready), 32'd0);
        @(negedge clk); #1;
        chk("wd_next_grant", 32'(bus.req_ready), 32'b1000);
        @(negedge clk); #1;
        bus.req_valid = 4'b0000;
        n = 1;
        while (bus.rsp_valid == '0 && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        chk("wd3_rsp_valid", 32'(bus.rsp_valid), 32'b1000);
        chk("wd3_rsp_sum", bus.rsp_sum, 32'hA5A5_5A5A);
    endtask

    initial begin
        op_x[0] = FP_ONE;        op_y[0] = FP_ONE;
        op_x[1] = FP_ONE;        op_y[1] = FP_TWO;
        op_x[2] = 32'h1111_0000; op_y[2] = 32'h0000_2222;
        op_x[3] = 32'hA5A5_0000; op_y[3] = 32'h0000_5A5A;

        tbl[0] = '{4'b0010, 4'b0010, FP_THREE,     1'b0, 3,  1'b0, 5};
        tbl[1] = '{4'b1111, 4'b0001, FP_TWO,       1'b0, 3,  1'b0, 5};
        tbl[2] = '{4'b1111, 4'b0010, FP_THREE,     1'b0, 3,  1'b0, 5};
        tbl[3] = '{4'b1111, 4'b0100, 32'h1111_2222, 1'b0, 3, 1'b0, 5};
        tbl[4] = '{4'b1111, 4'b1000, 32'hA5A5_5A5A, 1'b0, 3, 1'b0, 5};
        tbl[5] = '{4'b1111, 4'b0001, FP_TWO,       1'b0, 3,  1'b0, 5};
        tbl[6] = '{4'b0100, 4'b0100, 32'd0,        1'b1, 0,  1'b0, TIMEOUT + 2};
        tbl[7] = '{4'b1000, 4'b1000, FP_TWO,       1'b0, TIMEOUT,     1'b1, TIMEOUT + 2};
        tbl[8] = '{4'b0001, 4'b0001, 32'd0,        1'b1, TIMEOUT + 1, 1'b0, TIMEOUT + 2};
        tbl[9] = '{4'b0110, 4'b0010, FP_THREE,     1'b0, 1,  1'b0, 3};

        bus.req_valid = 4'b0001;
        #2 reset = 1'b0;
        @(negedge clk); @(negedge clk); #1;
        chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_add_start", 32'(bus.add_start), 32'd0);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("reset_add_x", bus.add_x, 32'd0);
        bus.req_valid = 4'b0000;
        reset = 1'b1;
        @(negedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            if (i == 1) reset_mid_wait();
            run_op(tbl[i]);
            if (i == 6) late_done_check();
        end
        withdraw_seq();
        bus.req_valid = 4'b0000;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
